// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode constants, request-kind enum, immediate bounds
// and the load/store/branch field packing used by instr_encoder.
package riscv_pkg;

  typedef enum logic [1:0] {
    KIND_LOAD    = 2'b00,
    KIND_STORE   = 2'b01,
    KIND_BRANCH  = 2'b10,
    KIND_INVALID = 2'b11
  } kind_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Representable immediate range of the 12-bit fields (in the core's units).
  localparam logic signed [63:0] IMM_MIN = -64'sd2048;
  localparam logic signed [63:0] IMM_MAX = 64'sd2047;

  // FIFO payload: {instr[31:0], addr[63:0]}.
  localparam int FIFO_W = 96;

  // Pack the fields of one request. Branch immediates are already in
  // halfword units, so imm[0] here is byte-offset bit 1.
  function automatic logic [31:0] encode(input kind_e kind,
                                         input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2,
                                         input logic [2:0] funct3,
                                         input logic [11:0] imm);
    logic [31:0] word;
    word = '0;
    case (kind)
      KIND_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      KIND_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      KIND_BRANCH: word = {imm[11], imm[9:4], rs2, rs1, funct3,
                           imm[3:0], imm[10], OPC_BRANCH};
      default:     word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// instr_fifo2: two-entry FIFO with registered occupancy. The head reads 0
// whenever the FIFO is empty so nothing stale is ever presented.
module instr_fifo2 #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_reg;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && (count_reg != 2'd2);
  assign pop_ok  = pop && (count_reg != 2'd0);

  // Storage, pointers and occupancy; reset discards all contents at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign head_data = (count_reg != 2'd0) ? mem[rd_ptr] : '0;
  assign count     = count_reg;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes load/store/branch requests into 32-bit words,
// tags each with a running byte address and queues them in instr_fifo2.
// Optional macro IMM_RANGE_CHECK_EN rejects immediates outside the 12-bit
// signed range; without it the immediate is simply truncated.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_imm,
  input  logic        start,
  input  logic [63:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  logic [63:0]       addr_reg;
  logic [63:0]       addr_next;
  logic [63:0]       cur_addr;
  logic              err_reg;
  logic [7:0]        err_count_reg;
  logic [1:0]        fifo_count;
  logic [FIFO_W-1:0] head_data;
  logic [31:0]       instr_word;
  logic              accept;
  logic              range_err;
  logic              reject;
  logic              enq;

`ifdef IMM_RANGE_CHECK_EN
  assign range_err = ($signed(in_imm) < IMM_MIN) || ($signed(in_imm) > IMM_MAX);
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[63:12];
  assign range_err     = 1'b0;
`endif

  assign in_ready   = (fifo_count < 2'd2);
  assign accept     = in_valid && in_ready;
  assign reject     = (kind_e'(in_kind) == KIND_INVALID) || range_err;
  assign enq        = accept && !reject;
  assign instr_word = encode(kind_e'(in_kind), in_rd, in_rs1, in_rs2,
                             in_funct3, in_imm[11:0]);

  // A coincident start takes effect for the word being enqueued this cycle.
  always_comb begin
    cur_addr  = start ? base_addr : addr_reg;
    addr_next = addr_reg;
    if (enq) begin
      addr_next = cur_addr + 64'd4;
    end else if (start) begin
      addr_next = base_addr;
    end
  end

  // Address counter, one-cycle reject pulse and saturating reject count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      err_reg       <= 1'b0;
      err_count_reg <= '0;
    end else begin
      addr_reg <= addr_next;
      err_reg  <= accept && reject;
      if (accept && reject && (err_count_reg != 8'hFF)) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  instr_fifo2 #(.W(FIFO_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (enq),
    .push_data ({instr_word, cur_addr}),
    .pop       (out_valid && out_ready),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign out_instr = head_data[95:64];
  assign out_addr  = head_data[63:0];
  assign err       = err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-computed encodings and
// addresses for instr_encoder (default build or IMM_RANGE_CHECK_EN).
module tb_instr_encoder;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [63:0] in_imm;
  logic        start;
  logic [63:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_addr;
  logic        err;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_errs;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .start     (start),
    .base_addr (base_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
    in_valid  = 1'b1;
    in_kind   = k;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_imm    = imm;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_kind = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_funct3 = '0; in_imm = '0; start = 1'b0; base_addr = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_addr",  out_addr,       64'd0);
    chk("rst_err",       64'(err),       64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Load rd=5 rs1=2 f3=011 imm=-8 at base 0x1000.
    start = 1'b1; base_addr = 64'h1000; tick(); start = 1'b0;
    send(2'b00, 5'd5, 5'd2, 5'd0, 3'b011, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("load_valid", 64'(out_valid), 64'd1);
    chk("load_instr", 64'(out_instr), 64'hFF81_3283);
    chk("load_addr",  out_addr,       64'h1000);
    out_ready = 1'b1; tick();
    chk("load_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Store then branch back to back from base 0x1000.
    start = 1'b1; base_addr = 64'h1000; tick(); start = 1'b0;
    send(2'b01, 5'd0, 5'd1, 5'd7, 3'b010, 64'd20);
    send(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 64'd8);
    chk("st_instr",    64'(out_instr), 64'h0070_AA23);
    chk("st_addr",     out_addr,       64'h1000);
    chk("full_ready",  64'(in_ready),  64'd0);
    out_ready = 1'b1; tick();
    chk("br_instr", 64'(out_instr), 64'h0020_8863);
    chk("br_addr",  out_addr,       64'h1004);
    tick();
    chk("br_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Backpressure: three loads, only two fit.
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 64'd0);
    chk("bp_ready1", 64'(in_ready), 64'd1);
    send(2'b00, 5'd2, 5'd0, 5'd0, 3'b000, 64'd0);
    chk("bp_ready2", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_kind = 2'b00; in_rd = 5'd3;
    tick();
    chk("bp_hold_ready", 64'(in_ready),  64'd0);
    chk("bp_hold_instr", 64'(out_instr), 64'h0000_0083);
    tick();
    chk("bp_stable_instr", 64'(out_instr), 64'h0000_0083);
    chk("bp_stable_addr",  out_addr,       64'h1008);
    out_ready = 1'b1; tick();
    chk("bp_w2_instr", 64'(out_instr), 64'h0000_0103);
    chk("bp_w2_addr",  out_addr,       64'h100C);
    chk("bp_reopen",   64'(in_ready),  64'd1);
    tick(); in_valid = 1'b0;
    chk("bp_w3_instr", 64'(out_instr), 64'h0000_0183);
    chk("bp_w3_addr",  out_addr,       64'h1010);
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Out-of-range immediate 2048.
    send(2'b00, 5'd0, 5'd0, 5'd0, 3'b000, 64'd2048);
`ifdef IMM_RANGE_CHECK_EN
    chk("rng_err",       64'(err),       64'd1);
    chk("rng_err_count", 64'(err_count), 64'd1);
    chk("rng_no_valid",  64'(out_valid), 64'd0);
    tick();
    chk("rng_err_pulse", 64'(err), 64'd0);
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 64'd0);
    chk("rng_next_instr", 64'(out_instr), 64'h0000_0083);
    chk("rng_next_addr",  out_addr,       64'h1014);
    exp_errs = 8'd1;
`else
    chk("trunc_err",   64'(err),       64'd0);
    chk("trunc_valid", 64'(out_valid), 64'd1);
    chk("trunc_instr", 64'(out_instr), 64'h8000_0003);
    chk("trunc_addr",  out_addr,       64'h1014);
    exp_errs = 8'd0;
`endif
    out_ready = 1'b1; tick();
    chk("rng_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // start coincides with an accept while one word is queued.
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 64'd0);
    start = 1'b1; base_addr = 64'h2000;
    send(2'b00, 5'd2, 5'd0, 5'd0, 3'b000, 64'd0);
    start = 1'b0;
    chk("sim_old_addr", out_addr, 64'h1018);
    out_ready = 1'b1; tick();
    chk("sim_new_instr", 64'(out_instr), 64'h0000_0103);
    chk("sim_new_addr",  out_addr,       64'h2000);
    send(2'b10, 5'd0, 5'd0, 5'd0, 3'b001, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sim_br_instr", 64'(out_instr), 64'hFE00_1EE3);
    chk("sim_br_addr",  out_addr,       64'h2004);
    tick();
    chk("sim_drained", 64'(out_valid), 64'd0);

    // Kind 11: single pulse, then saturation.
    send(2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 64'd0);
    chk("k3_err",       64'(err),       64'd1);
    chk("k3_err_count", 64'(err_count), 64'(exp_errs + 8'd1));
    chk("k3_no_valid",  64'(out_valid), 64'd0);
    tick();
    chk("k3_err_pulse", 64'(err), 64'd0);
    in_valid = 1'b1; in_kind = 2'b11;
    repeat (260) tick();
    in_valid = 1'b0;
    tick();
    chk("sat_err_count", 64'(err_count), 64'd255);
    chk("sat_no_valid",  64'(out_valid), 64'd0);
    out_ready = 1'b0;
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 64'd0);
    send(2'b00, 5'd2, 5'd0, 5'd0, 3'b000, 64'd0);
    chk("k3_addr_kept", out_addr,       64'h2008);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);

    // Asynchronous reset mid-stream.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid",     64'(out_valid), 64'd0);
    chk("arst_err_count", 64'(err_count), 64'd0);
    chk("arst_instr",     64'(out_instr), 64'd0);
    chk("arst_ready",     64'(in_ready),  64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_addr",  out_addr,       64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 The module SHALL have these request ports: in_valid input 1, request present; in_ready output 1, request accepted when high with in_valid; in_kind input 2, 00 load, 01 store, 10 branch, 11 invalid.
REQ-003 The module SHALL have these field ports: in_rd input 5, load destination; in_rs1 input 5; in_rs2 input 5, store/branch source; in_funct3 input 3; in_imm input 64, signed immediate.
REQ-004 in_imm SHALL use the core's immediate units: bytes for load/store; halfwords (byte offset >> 1) for branch.
REQ-005 The module SHALL have these address ports: start input 1, loads base address; base_addr input 64.
REQ-006 The module SHALL have these output ports: out_valid output 1; out_ready input 1; out_instr output 32, encoded word; out_addr output 64, word byte address.
REQ-007 The module SHALL have these error ports: err output 1, one-cycle reject pulse; err_count output 8, saturating reject count.

Function
REQ-008 The module SHALL encode each accepted request as a 32-bit instruction.
- Load: imm[11:0], rs1, funct3, rd, 0000011.
- Store: imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011.
- Branch: imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], 1100011.
REQ-009 Decoding any encoded word's immediate (load/store/branch field layout, sign-extended to 64 bits) SHALL return in_imm exactly when in_imm is within [-2048, 2047].
REQ-010 The module SHALL hold encoded words in a 2-entry FIFO of {instr, addr}; in_ready SHALL equal (count < 2), from registered state only.
REQ-011 The module SHALL write the encoded word to the FIFO in the accept cycle; the earliest out_valid SHALL be the next cycle (latency 1).
REQ-012 out_valid SHALL equal (count > 0); out_instr/out_addr SHALL show the head entry and stay stable while out_valid && !out_ready.
REQ-013 Push and pop in the same cycle at count 1 SHALL leave count at 1 and keep word order.
REQ-014 The module SHALL keep a 64-bit address counter: start loads base_addr; each enqueued word takes the current counter value and the counter then advances by 4, wrapping modulo 2^64.
REQ-015 When start and an accept coincide, the accepted word SHALL take base_addr and the counter SHALL become base_addr+4.
REQ-016 start SHALL NOT change the addresses of words already in the FIFO.
REQ-017 A rejected request SHALL still be accepted (in_ready high), but SHALL NOT be enqueued and SHALL NOT advance the counter.
REQ-018 A rejected request SHALL pulse err for exactly one cycle and increment err_count, saturating at 255.
REQ-019 in_kind 11 SHALL always be rejected.

Reset
REQ-020 With rst_n low the module SHALL clear: FIFO count 0, out_valid 0, address counter 0, err 0, err_count 0.
REQ-021 out_instr and out_addr SHALL read 0 while out_valid is 0 after reset.
REQ-022 Reset asserted mid-operation SHALL discard all FIFO contents immediately, with no partial output.

Configuration
REQ-023 With macro IMM_RANGE_CHECK_EN defined, a request with in_imm outside [-2048, 2047] SHALL be rejected per REQ-017 and REQ-018.
REQ-024 Without IMM_RANGE_CHECK_EN, in_imm SHALL be truncated to bits [11:0] with no range error; only in_kind 11 SHALL reject.

Structure
REQ-025 A shared package riscv_pkg SHALL hold the opcode constants OPC_LOAD, OPC_STORE and OPC_BRANCH, the 2-bit kind enum, and IMM_MIN/IMM_MAX.
REQ-026 The 2-entry FIFO SHALL be a sub-module instr_fifo2, parameterised on payload width (96).

Verification
REQ-027 Load: after reset, start with base_addr=0x1000, then load rd=5, rs1=2, funct3=011, imm=-8 -> out_instr=0xFF813283, out_addr=0x1000.
REQ-028 Store then branch, back to back: store rs2=7, rs1=1, funct3=010, imm=20 -> 0x0070AA23 @0x1000; then branch rs1=1, rs2=2, funct3=000, imm=8 (16 bytes) -> 0x00208863 @0x1004.
REQ-029 Backpressure: hold out_ready=0 and offer 3 requests -> in_ready drops after 2 accepts; outputs stay stable; release -> words arrive in order at addresses +0, +4, +8.
REQ-030 Range reject, with IMM_RANGE_CHECK_EN defined: load imm=2048 -> err pulses 1 cycle, err_count=1, no out_valid, and the next word takes the unadvanced address.
REQ-031 Kind 11 and saturation: 260 kind-11 requests -> err_count=255; then assert reset mid-stream with 2 words queued -> out_valid=0 and err_count=0 immediately.
REQ-032 Simultaneous events: start with base_addr=0x2000 in the same cycle as an accept while 1 word is queued -> the queued word keeps its old address; the new word gets 0x2000; the next word gets 0x2004.
